// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM device-side responder: decodes quad read (0xEB) and quad write (0x38)
// commands from an oversampled sck/ce_n/dio bus and accesses a byte-wide synchronous SRAM.
module psram_qspi_responder #(
    parameter int ADDR_W = 24,
    parameter int DUMMY  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ce_n,
    input  logic [3:0]        din,
    output logic [3:0]        dout,
    output logic [3:0]        douten,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam logic [7:0] DUMMY_CNT = 8'(DUMMY);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]        sck_pipe_reg;
    logic              sck_dly_reg;
    logic [1:0]        ce_pipe_reg;
    logic [3:0]        din_s;
    logic              ce_s;
    logic              sck_rise;
    logic              sck_fall;

    logic [7:0]        cnt_reg;
    logic [7:0]        cmd_reg;
    logic [23:0]       addr_reg;
    logic              is_write_reg;
    logic [7:0]        prefetch_reg;
    logic              re_dly_reg;
    logic              low_next_reg;
    logic              wr_half_reg;
    logic [3:0]        wr_hi_reg;
    logic [3:0]        dout_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_re_reg;
    logic              mem_we_reg;
    logic [7:0]        mem_wdata_reg;

    logic [7:0]        cmd_shift;
    logic [23:0]       addr_shift;

    // Two-flop synchronizers; sck keeps a third copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_pipe_reg <= 2'b00;
            sck_dly_reg  <= 1'b0;
            ce_pipe_reg  <= 2'b11;
        end else begin
            sck_pipe_reg <= {sck_pipe_reg[0], sck};
            sck_dly_reg  <= sck_pipe_reg[1];
            ce_pipe_reg  <= {ce_pipe_reg[0], ce_n};
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_din_sync
        logic [1:0] pipe_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_reg <= 2'b00;
            end else begin
                pipe_reg <= {pipe_reg[0], din[gi]};
            end
        end
        assign din_s[gi] = pipe_reg[1];
    end

    assign ce_s       = ce_pipe_reg[1];
    assign sck_rise   = sck_pipe_reg[1] & ~sck_dly_reg;
    assign sck_fall   = ~sck_pipe_reg[1] & sck_dly_reg;
    assign cmd_shift  = {cmd_reg[6:0], din_s[0]};
    assign addr_shift = {addr_reg[19:0], din_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg != S_IDLE && ce_s) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (!ce_s) state_next = S_CMD;
                S_CMD:   if (sck_rise && cnt_reg == 8'd7)
                             state_next = (cmd_shift == CMD_READ || cmd_shift == CMD_WRITE)
                                          ? S_ADDR : S_IGNORE;
                S_ADDR:  if (sck_rise && cnt_reg == 8'd5)
                             state_next = is_write_reg ? S_WDATA : S_DUMMY;
                S_DUMMY: if (sck_fall && cnt_reg == DUMMY_CNT) state_next = S_RDATA;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        douten = 4'h0;
        if (state_reg == S_RDATA) douten = 4'hF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            cmd_reg       <= '0;
            addr_reg      <= '0;
            is_write_reg  <= 1'b0;
            prefetch_reg  <= '0;
            re_dly_reg    <= 1'b0;
            low_next_reg  <= 1'b0;
            wr_half_reg   <= 1'b0;
            wr_hi_reg     <= '0;
            dout_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
        end else begin
            mem_re_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            re_dly_reg <= mem_re_reg;
            if (re_dly_reg) prefetch_reg <= mem_rdata;
            // Write address advances the clk after the strobe so mem_we sees the current address.
            if (mem_we_reg) mem_addr_reg <= mem_addr_reg + 1'b1;

            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (sck_rise) begin
                cnt_reg <= cnt_reg + 8'd1;
            end

            if (!ce_s) begin
                case (state_reg)
                    S_IDLE: begin
                        dout_reg     <= '0;
                        low_next_reg <= 1'b0;
                        wr_half_reg  <= 1'b0;
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            cmd_reg <= cmd_shift;
                            if (cnt_reg == 8'd7) is_write_reg <= (cmd_shift == CMD_WRITE);
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            addr_reg <= addr_shift;
                            if (cnt_reg == 8'd5) begin
                                mem_addr_reg <= addr_shift[ADDR_W-1:0];
                                mem_re_reg   <= ~is_write_reg;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (state_next == S_RDATA) begin
                            dout_reg     <= prefetch_reg[7:4];
                            low_next_reg <= 1'b1;
                        end
                    end
                    S_RDATA: begin
                        if (sck_fall) begin
                            if (low_next_reg) begin
                                dout_reg     <= prefetch_reg[3:0];
                                low_next_reg <= 1'b0;
                                mem_addr_reg <= mem_addr_reg + 1'b1;
                                mem_re_reg   <= 1'b1;
                            end else begin
                                dout_reg     <= prefetch_reg[7:4];
                                low_next_reg <= 1'b1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (sck_rise) begin
                            if (wr_half_reg) begin
                                mem_wdata_reg <= {wr_hi_reg, din_s};
                                mem_we_reg    <= 1'b1;
                                wr_half_reg   <= 1'b0;
                            end else begin
                                wr_hi_reg   <= din_s;
                                wr_half_reg <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                // Any partially received write byte is dropped here.
                wr_half_reg  <= 1'b0;
                low_next_reg <= 1'b0;
            end
        end
    end

    assign dout      = dout_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_re    = mem_re_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Bench for psram_qspi_responder: acts as QSPI controller and backing SRAM,
// with scoreboard queues for expected write strobes and read nibbles.
module tb_psram_qspi_responder;
    localparam int ADDR_W = 24;
    localparam int DUMMY  = 6;
    localparam int HALF   = 80;

    logic              clk = 1'b0;
    logic              rst;
    logic              sck;
    logic              ce_n;
    logic [3:0]        din;
    logic [3:0]        dout;
    logic [3:0]        douten;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;
    int re_cnt = 0;
    int we_cnt = 0;

    logic [7:0]  mem [int];
    logic [31:0] exp_wr_q [$];
    logic [3:0]  exp_nib_q [$];

    psram_qspi_responder #(.ADDR_W(ADDR_W), .DUMMY(DUMMY)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .ce_n      (ce_n),
        .din       (din),
        .dout      (dout),
        .douten    (douten),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Backing SRAM: registered read, one-clk latency.
    always @(posedge clk) begin
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
        if (mem_re) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (mem_re) re_cnt++;
            if (mem_we) begin
                we_cnt++;
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(mem_addr), {8'h00, e[31:8]});
                    check("wr_data", 32'(mem_wdata), {24'h0, e[7:0]});
                end
            end
        end
    end

    task automatic begin_txn();
        sck  = 1'b0;
        ce_n = 1'b0;
        #(HALF);
    endtask

    task automatic end_txn();
        sck = 1'b0;
        #(HALF);
        ce_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic send_nib(input logic [3:0] n);
        din = n;
        #(HALF);
        sck = 1'b1;
        #(HALF);
        sck = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_nib({3'b000, c[i]});
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    endtask

    task automatic dummy_cycles();
        din = 4'h0;
        for (int i = 0; i < DUMMY; i++) begin
            #(HALF);
            sck = 1'b1;
            #(HALF);
            check("dummy_oe", 32'(douten), 32'h0);
            sck = 1'b0;
        end
    endtask

    task automatic read_nib();
        logic [3:0] e;
        #(HALF);
        e = (exp_nib_q.size() != 0) ? exp_nib_q.pop_front() : 4'hx;
        check("rd_nib", 32'(dout), 32'(e));
        check("rd_oe", 32'(douten), 32'hF);
        sck = 1'b1;
        #(HALF);
        sck = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_nib_q.push_back(b[7:4]);
        exp_nib_q.push_back(b[3:0]);
    endtask

    initial begin
        int re0, we0;
        rst = 1'b1;
        sck = 1'b0;
        ce_n = 1'b1;
        din = 4'h0;
        mem[32'hFFFFFF] = 8'h5A;
        mem[32'h000000] = 8'hC3;
        mem[32'h000021] = 8'h77;
        #52;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_douten", 32'(douten), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst = 1'b0;
        #(2 * HALF);

        // Quad write of two bytes at 0x10.
        we0 = we_cnt;
        exp_wr_q.push_back({24'h000010, 8'hA5});
        exp_wr_q.push_back({24'h000011, 8'h3C});
        begin_txn();
        send_cmd(8'h38);
        send_addr(24'h000010);
        send_nib(4'hA); send_nib(4'h5); send_nib(4'h3); send_nib(4'hC);
        end_txn();
        check("wr_count", 32'(we_cnt - we0), 32'd2);
        check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        // Quad read of the bytes just written.
        push_byte(8'hA5);
        push_byte(8'h3C);
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000010);
        dummy_cycles();
        for (int i = 0; i < 4; i++) read_nib();
        end_txn();

        // Read wrapping from the top of the address space.
        push_byte(8'h5A);
        push_byte(8'hC3);
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'hFFFFFF);
        dummy_cycles();
        for (int i = 0; i < 4; i++) read_nib();
        end_txn();

        // Unsupported command is ignored until ce_n rises.
        re0 = re_cnt;
        we0 = we_cnt;
        begin_txn();
        send_cmd(8'h9F);
        for (int i = 0; i < 8; i++) begin
            send_nib(4'(i));
            check("ign_oe", 32'(douten), 32'h0);
        end
        end_txn();
        check("ign_re", 32'(re_cnt - re0), 32'd0);
        check("ign_we", 32'(we_cnt - we0), 32'd0);
        push_byte(8'hA5);
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000010);
        dummy_cycles();
        for (int i = 0; i < 2; i++) read_nib();
        end_txn();

        // Write aborted after three nibbles: only the first byte lands.
        we0 = we_cnt;
        exp_wr_q.push_back({24'h000020, 8'h12});
        begin_txn();
        send_cmd(8'h38);
        send_addr(24'h000020);
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3);
        end_txn();
        check("abort_wr_count", 32'(we_cnt - we0), 32'd1);
        check("abort_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("abort_mem21", 32'(mem[32'h21]), 32'h77);

        // Asynchronous reset in the middle of a read.
        push_byte(8'hA5);
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000010);
        dummy_cycles();
        for (int i = 0; i < 2; i++) read_nib();
        #30;
        check("pre_rst_oe", 32'(douten), 32'hF);
        rst = 1'b1;
        #1;
        check("arst_oe", 32'(douten), 32'h0);
        check("arst_re", 32'(mem_re), 32'h0);
        check("arst_we", 32'(mem_we), 32'h0);
        #9;
        ce_n = 1'b1;
        #20;
        rst = 1'b0;
        #(4 * HALF);
        push_byte(8'hA5);
        push_byte(8'h3C);
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000010);
        dummy_cycles();
        for (int i = 0; i < 4; i++) read_nib();
        end_txn();
        check("nib_q_empty", 32'(exp_nib_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
